dnn_mac_sched: RTL and testbench
================================

# dnn_mac_sched

Sequencer for the 4-4-2 fully connected DNN that time-multiplexes one shared unsigned 5×N multiply-accumulate unit across all 24 products instead of instantiating 24 multipliers. It captures one input vector plus all 24 weights on an `in_ready` strobe. It then steps layer 1 (4 hidden neurons × 4 inputs) and layer 2 (2 outputs × 4 hidden), and presents `out0`/`out1` with one-cycle ready pulses. It sits directly under `top` as the area-reduced alternative to the parallel DNN datapath.

## Interface
- No parameters; all widths are fixed by the network shape.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_ready` in 1: start strobe; sampled only in IDLE.
- `x_flat` in 20: `x_flat[5*i +: 5]` = x_i, i=0..3, unsigned.
- `w1_flat` in 80: `w1_flat[5*(4*i+j) +: 5]` = w_{i,j+4} (input i → hidden j), unsigned.
- `w2_flat` in 40: `w2_flat[5*(2*j+k) +: 5]` = w_{j+4,k+8} (hidden j → output k), unsigned.
- `out0` out 17: output neuron 8 result; holds until overwritten.
- `out1` out 17: output neuron 9 result; holds until overwritten.
- `out0_ready` out 1: one-cycle pulse when `out0` is updated.
- `out1_ready` out 1: one-cycle pulse when `out1` is updated.
- `busy` out 1: high from capture until `out1` is written.

## Operation
- Reset values: state IDLE, `out0`=`out1`=0, `out0_ready`=`out1_ready`=0, `busy`=0, accumulator=0, hidden regs=0, step counter=0.
- FSM states and transitions:
  - IDLE → L1 on `in_ready`=1. At that edge, `x_flat`, `w1_flat` and `w2_flat` are captured into internal registers. Later input changes do not affect the job.
  - L1: a 4-bit counter c=0..15, with j=c[3:2] and i=c[1:0]. Each cycle does acc += x_i·w_{i,j+4}. The accumulator clears at i=0, and h_j is written at i=3. L1 → L2 after c=15.
  - L2: a 3-bit counter c=0..7, with k=c[2], j=c[1:0]. Each cycle does acc += h_j·w_{j+4,k+8}. The accumulator clears at j=0, and `out_k` is written at j=3. L2 → IDLE after c=7.
- Arithmetic widths:
  - Layer-1 product is 10 bits; h_j is 12 bits exact (max 3844).
  - Layer-2 product is 17 bits; the accumulator is 19 bits exact (max 476656).
  - Output narrowing to 17 bits is set by the configuration macro.
- Boundary rules:
  - `in_ready` asserted while `busy`=1 is ignored, with no queuing. `in_ready` held high starts back-to-back jobs.
  - A new job never clears `out0`/`out1` until each is rewritten.
  - `rst_n` low at any time, including mid-L1 or mid-L2, immediately returns all outputs and state to reset values. The partial job is discarded.

## Timing
- Edge E0 samples `in_ready`=1 in IDLE (capture); `busy`=1 after E0.
- Edges E1..E16 perform the L1 MACs. h_j is written at E(4j+4).
- Edges E17..E20 perform the k=0 MACs. At E20, `out0` updates and `out0_ready`=1 for exactly the cycle E20–E21.
- Edges E21..E24 perform the k=1 MACs. At E24, `out1` updates, `out1_ready`=1 for the cycle E24–E25, `busy`=0, and state=IDLE.
- Earliest next capture is E25, giving a throughput of one job per 25 cycles.
- `out0_ready` and `out1_ready` are never high in the same cycle.

## Configuration
- `DNN_OUT_SAT_EN` defined: an output accumulator value above 131071 saturates to 17'h1FFFF.
- `DNN_OUT_SAT_EN` undefined: the output is `acc[16:0]` (modulo 2^17). There is no saturation logic.
- Hidden-layer behaviour is identical in both builds.

## Test plan
- All x=1, all w=1, `in_ready` pulse at E0 → h=4 each; `out0`=16 with `out0_ready` pulse after E20; `out1`=16 with pulse after E24; `busy` low after E24.
- Ordering check:
  - Stimulus: x0=1, x1=x2=x3=0, w04=2, w05=3, all other w1=0, w48=5, w58=7, w49=1, all other w2=0.
  - Response: `out0`=31, `out1`=2.
- All x=31, all w=31 → with `DNN_OUT_SAT_EN`, `out0`=`out1`=131071; without it, `out0`=`out1`=83440.
- Busy and back-to-back handling:
  - Stimulus: pulse `in_ready` at E5 during job A (all 1s), and change `x_flat` to all 2s during job A.
  - Response: job A still yields 16/16 and no second job starts.
  - Then hold `in_ready` high from E24: the second capture occurs at E25, and its `out0` (all x=2, w=1 → 32) arrives at E45.
- Reset during job:
  - Stimulus: assert `rst_n`=0 at E18 (mid-L2), release, then run a job with all 1s.
  - Response: outputs, ready pulses and `busy` go 0 asynchronously; the new job returns 16/16 with normal timing.

Source files
------------

// File: rtl/dnn_mac_sched.sv
// 4-4-2 DNN sequencer sharing one multiply-accumulate unit across all 24 products.
// Build option: define DNN_OUT_SAT_EN to saturate outputs at 17'h1FFFF instead of wrapping.
module dnn_mac_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_ready,
  input  logic [19:0] x_flat,
  input  logic [79:0] w1_flat,
  input  logic [39:0] w2_flat,
  output logic [16:0] out0,
  output logic [16:0] out1,
  output logic        out0_ready,
  output logic        out1_ready,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_L1   = 2'd1;
  localparam logic [1:0] S_L2   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        c_q, c_d;
  logic [18:0]       acc_q;
  logic [3:0][11:0]  h_q;
  logic [19:0]       x_q;
  logic [79:0]       w1_q;
  logic [39:0]       w2_q;
  logic [16:0]       out0_q, out1_q;
  logic              rdy0_q, rdy1_q;

  logic [11:0] mul_a;
  logic [4:0]  mul_b;
  logic [16:0] prod;
  logic [18:0] acc_sum;
  logic [16:0] out_val;
  logic        clr, last;

  // L1 counter is {j,i}; the weight index is {i,j}, so the fields swap for the lookup
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    mul_a   = '0;
    mul_b   = '0;
    clr     = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_ready) begin
          state_d = S_L1;
          c_d     = '0;
        end
      end
      S_L1: begin
        mul_a = {7'd0, x_q[5*c_q[1:0] +: 5]};
        mul_b = w1_q[5*{c_q[1:0], c_q[3:2]} +: 5];
        clr   = (c_q[1:0] == 2'd0);
        last  = (c_q[1:0] == 2'd3);
        c_d   = c_q + 4'd1;
        if (c_q == 4'd15) begin
          state_d = S_L2;
          c_d     = '0;
        end
      end
      S_L2: begin
        mul_a = h_q[c_q[1:0]];
        mul_b = w2_q[5*{c_q[1:0], c_q[2]} +: 5];
        clr   = (c_q[1:0] == 2'd0);
        last  = (c_q[1:0] == 2'd3);
        c_d   = c_q + 4'd1;
        if (c_q[2:0] == 3'd7) begin
          state_d = S_IDLE;
          c_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        c_d     = '0;
      end
    endcase
  end

  assign prod    = {5'd0, mul_a} * {12'd0, mul_b};
  assign acc_sum = (clr ? 19'd0 : acc_q) + {2'd0, prod};

`ifdef DNN_OUT_SAT_EN
  assign out_val = (acc_sum > 19'd131071) ? 17'h1FFFF : acc_sum[16:0];
`else
  assign out_val = acc_sum[16:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      acc_q   <= '0;
      h_q     <= '0;
      x_q     <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      if (state_q == S_IDLE && in_ready) begin
        x_q  <= x_flat;
        w1_q <= w1_flat;
        w2_q <= w2_flat;
      end
      if (state_q == S_L1) begin
        acc_q <= acc_sum;
        if (last) h_q[c_q[3:2]] <= acc_sum[11:0];
      end
      if (state_q == S_L2) begin
        acc_q <= acc_sum;
        if (last && !c_q[2]) begin
          out0_q <= out_val;
          rdy0_q <= 1'b1;
        end
        if (last && c_q[2]) begin
          out1_q <= out_val;
          rdy1_q <= 1'b1;
        end
      end
    end
  end

  assign out0       = out0_q;
  assign out1       = out1_q;
  assign out0_ready = rdy0_q;
  assign out1_ready = rdy1_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dnn_mac_sched.sv
// Directed + random bench for dnn_mac_sched against an arithmetic network model.
module tb_dnn_mac_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_ready = 1'b0;
  logic [19:0] x_flat = '0;
  logic [79:0] w1_flat = '0;
  logic [39:0] w2_flat = '0;
  logic [16:0] out0, out1;
  logic        out0_ready, out1_ready, busy;

  int errs = 0;
  int checks = 0;
  logic [16:0] prev0 = '0;
  logic [16:0] prev1 = '0;

  dnn_mac_sched dut (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready),
    .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat),
    .out0(out0), .out1(out1), .out0_ready(out0_ready),
    .out1_ready(out1_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Whole-network reference: hidden sums, output sums, then narrowing
  function automatic logic [16:0] narrow(input int v);
`ifdef DNN_OUT_SAT_EN
    return (v > 131071) ? 17'h1FFFF : 17'(v);
`else
    return 17'(v % 131072);
`endif
  endfunction

  task automatic model(input logic [19:0] x, input logic [79:0] w1, input logic [39:0] w2,
                       output logic [16:0] o0, output logic [16:0] o1);
    int h[4];
    int o[2];
    for (int j = 0; j < 4; j++) begin
      h[j] = 0;
      for (int i = 0; i < 4; i++) h[j] += int'(x[5*i +: 5]) * int'(w1[5*(4*i+j) +: 5]);
    end
    for (int k = 0; k < 2; k++) begin
      o[k] = 0;
      for (int j = 0; j < 4; j++) o[k] += h[j] * int'(w2[5*(2*j+k) +: 5]);
    end
    o0 = narrow(o[0]);
    o1 = narrow(o[1]);
  endtask

  task automatic run_job(input logic [19:0] x, input logic [79:0] w1, input logic [39:0] w2,
                         input logic [16:0] e0, input logic [16:0] e1);
    int n0 = -1;
    int n1 = -1;
    int both = 0;
    x_flat = x; w1_flat = w1; w2_flat = w2;
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    chk("busy_after_E0", busy, 1);
    for (int n = 1; n <= 30; n++) begin
      step();
      if (out0_ready && out1_ready) both++;
      if (n == 19) chk("out0_holds_prev", out0, prev0);
      if (out0_ready && n0 < 0) begin n0 = n; chk("out0_value", out0, e0); end
      if (out1_ready && n1 < 0) begin
        n1 = n;
        chk("out1_value", out1, e1);
        chk("busy_clear", busy, 0);
      end
    end
    chk("out0_ready_edge", n0, 20);
    chk("out1_ready_edge", n1, 24);
    chk("ready_overlap", both, 0);
    prev0 = e0;
    prev1 = e1;
  endtask

  initial begin : main
    logic [19:0] ones_x, twos_x, max_x, rx;
    logic [79:0] ones_w1, max_w1, rw1;
    logic [39:0] ones_w2, max_w2, rw2;
    logic [95:0] r96;
    logic [16:0] e0, e1;
    int n0;

    ones_x = {4{5'd1}};  twos_x = {4{5'd2}};  max_x = {4{5'd31}};
    ones_w1 = {16{5'd1}}; max_w1 = {16{5'd31}};
    ones_w2 = {8{5'd1}};  max_w2 = {8{5'd31}};

    // reset state
    #12;
    chk("rst_out0", out0, 0);
    chk("rst_out1", out1, 0);
    chk("rst_rdy0", out0_ready, 0);
    chk("rst_rdy1", out1_ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_job(ones_x, ones_w1, ones_w2, 17'd16, 17'd16);

    // ordering: x0=1, w04=2, w05=3, w48=5, w58=7, w49=1
    run_job(20'd1, 80'd2 | (80'd3 << 5), 40'd5 | (40'd1 << 5) | (40'd7 << 10), 17'd31, 17'd2);

`ifdef DNN_OUT_SAT_EN
    run_job(max_x, max_w1, max_w2, 17'd131071, 17'd131071);
`else
    run_job(max_x, max_w1, max_w2, 17'd83440, 17'd83440);
`endif

    // busy-ignore then back-to-back start held from E24
    x_flat = ones_x; w1_flat = ones_w1; w2_flat = ones_w2;
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    for (int n = 1; n <= 23; n++) begin
      if (n == 5) begin in_ready = 1'b1; x_flat = twos_x; end
      step();
      if (n == 5) in_ready = 1'b0;
    end
    in_ready = 1'b1;
    step();
    chk("bb_A_out0", out0, 16);
    chk("bb_A_out1", out1, 16);
    chk("bb_busy_E24", busy, 0);
    step();
    in_ready = 1'b0;
    chk("bb_busy_E25", busy, 1);
    n0 = -1;
    for (int n = 26; n <= 50; n++) begin
      step();
      if (out0_ready && n0 < 0) begin n0 = n; chk("bb_B_out0", out0, 32); end
      if (out1_ready) chk("bb_B_out1", out1, 32);
    end
    chk("bb_B_out0_edge", n0, 45);
    prev0 = 17'd32; prev1 = 17'd32;

    // random jobs
    for (int t = 0; t < 5; t++) begin
      r96 = {$urandom, $urandom, $urandom};
      rx  = 20'($urandom);
      rw1 = r96[79:0];
      rw2 = 40'({$urandom, $urandom});
      if (t == 0) begin rx = 20'($urandom_range(0, 3)); end
      model(rx, rw1, rw2, e0, e1);
      run_job(rx, rw1, rw2, e0, e1);
    end

    // mid-L2 reset discards the job
    model(ones_x, ones_w1, ones_w2, e0, e1);
    chk("model_ones", e0, 16);
    x_flat = twos_x; w1_flat = ones_w1; w2_flat = ones_w2;
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    for (int n = 1; n <= 17; n++) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out0", out0, 0);
    chk("mid_rst_out1", out1, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", {out0_ready, out1_ready}, 0);
    step();
    step();
    chk("mid_rst_hold", out0, 0);
    rst_n = 1'b1;
    prev0 = '0; prev1 = '0;
    step();
    run_job(ones_x, ones_w1, ones_w2, e0, e1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
